dataset_writer: RTL and testbench
=================================

Name: dataset_writer

Overview:
- Write-side counterpart of the regression dataset memory. The data loader reads X/Y pairs by address; this block fills that memory.
- Accepts X/Y sample pairs over a valid/ready stream and writes them to consecutive addresses starting at 0.
- Counts the samples written, then pulses `start_out` to launch the regression controller once the final write has landed.

Parameters:
- DATA_W, 20, width of each X and Y sample.
- ADDR_W, 8, memory address width.
- DEPTH, 150, maximum number of samples per load; legal range 1..2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  begins a new load; restarts the load if one is in progress.
- in_valid  input  1  sample pair present on in_x/in_y.
- in_ready  output  1  block can accept a sample this cycle.
- in_x  input  DATA_W  X sample.
- in_y  input  DATA_W  Y sample.
- in_last  input  1  qualifies the accepted sample as the final one of the set.
- wr_en  output  1  memory write strobe.
- wr_addr  output  ADDR_W  memory write address.
- wr_x  output  DATA_W  X write data.
- wr_y  output  DATA_W  Y write data.
- count  output  ADDR_W+1  number of samples written in the current or last load.
- done  output  1  dataset complete; held high.
- start_out  output  1  one-cycle pulse to the regression controller.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; wr_en, start_out, done, wr_addr, wr_x, wr_y, count and the internal pointer all 0.
- in_ready is combinational: (state==LOAD) && !load_start.
- A sample is accepted when in_valid && in_ready.
- States:
  - IDLE: waits for load_start.
  - LOAD: accepts samples.
  - FINISH: one cycle, final write in flight.
  - DONE: holds the result.
- load_start in any state:
  - next state = LOAD;
  - pointer and count cleared, done cleared;
  - no sample accepted that cycle;
  - a write already registered for this cycle still completes.
- LOAD, on accept at cycle T:
  - at T+1: wr_en=1, wr_addr=pointer, wr_x/wr_y = the accepted sample, count=pointer+1;
  - pointer increments at the same edge;
  - wr_en=0 on every cycle with no accept in the previous cycle;
  - wr_addr/wr_x/wr_y hold their last value when wr_en=0.
- Final sample = accepted with in_last=1, or accepted while pointer==DEPTH-1. For a final accept at cycle T:
  - T+1: state=FINISH, final write issued, in_ready=0;
  - T+2: state=DONE, start_out=1 for exactly one cycle, done=1;
  - done holds until the next load_start or reset.
- DONE: in_ready=0, further in_valid is ignored, count is held.
- Pointer never exceeds DEPTH-1; there is no wrap-around. A DEPTH-th sample always terminates the load, regardless of in_last.
- in_valid may drop at any time; the block tolerates gaps with no timeout.
- Arithmetic: pointer is ADDR_W bits and count is ADDR_W+1 bits, both unsigned, so count reaches DEPTH without overflow.

Optional Feature:
- Macro: DATASET_WRITER_CHECKSUM_EN.
- When defined:
  - adds output checksum [DATA_W-1:0], a modulo-2^DATA_W running sum of in_x+in_y over all accepted samples;
  - cleared on reset and load_start;
  - updated at the same edge as the corresponding write;
  - stable from the DONE entry cycle onward.
- When undefined: no port, no logic; all other behaviour identical.

Test Plan:
- Reset mid-load: 3 samples accepted, assert reset -> wr_en=0, count=0, state IDLE immediately; then load_start -> load begins at addr 0.
- Short set: load_start, then 4 back-to-back samples X=1..4, Y=10..40, last on the 4th -> writes at addr 0..3 on consecutive cycles; start_out pulses 2 cycles after the 4th accept; count=4, done=1.
- Full set: DEPTH=150, 150 samples with in_last never asserted -> final write at addr 149; count=150; in_ready low from then on; the extra sample offered after that is never accepted.
- Gapped stream: in_valid toggled 1,0,0,1,1 -> exactly 3 writes at addr 0,1,2; wr_en asserted only the cycle after each accept.
- Restart: 5 samples accepted, then load_start with in_valid=1 -> that sample is not accepted; next accept writes addr 0; count restarts at 1; done stays 0.
- Checksum (macro on): samples (5,7), (0xFFFFF,2), last -> checksum = 0x0000D (wraps); macro off -> design compiles without the checksum port.

Source files
------------

// File: rtl/dataset_writer.sv
// Streams X/Y sample pairs into consecutive dataset memory addresses starting at 0, then pulses start_out once the final write has landed.
// Optional running X+Y checksum output is enabled by defining DATASET_WRITER_CHECKSUM_EN.
module dataset_writer #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 150
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_x,
    output logic [DATA_W-1:0] wr_y,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              start_out
`ifdef DATASET_WRITER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_ready;
    logic              w_accept;
    logic              w_final;

    assign w_accept = in_valid && w_ready;
    assign w_final  = w_accept && (in_last || (r_ptr == LAST_PTR));
    assign in_ready = w_ready;

    always_comb begin
        w_next  = r_state;
        w_ready = (r_state == S_LOAD) && !load_start;
        if (load_start) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:   if (w_final) w_next = S_FINISH;
                S_FINISH: w_next = S_DONE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_x      <= '0;
            wr_y      <= '0;
            count     <= '0;
            done      <= 1'b0;
            start_out <= 1'b0;
        end else begin
            wr_en     <= w_accept;
            start_out <= (r_state == S_FINISH) && !load_start;
            if (load_start) begin
                r_ptr <= '0;
                count <= '0;
                done  <= 1'b0;
            end else begin
                if (r_state == S_FINISH) begin
                    done <= 1'b1;
                end
                if (w_accept) begin
                    wr_addr <= r_ptr;
                    wr_x    <= in_x;
                    wr_y    <= in_y;
                    count   <= {1'b0, r_ptr} + (ADDR_W+1)'(1);
                    // Hold at the last slot so the pointer never leaves the memory.
                    if (r_ptr != LAST_PTR) begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
            end
        end
    end

`ifdef DATASET_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (load_start) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + in_x + in_y;
        end
    end

    assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_dataset_writer.sv
// Randomized scoreboard bench for dataset_writer against a behavioural load model.
// Build with DATASET_WRITER_CHECKSUM_EN defined to also check the checksum output.
module tb_dataset_writer;
    localparam int DW    = 20;
    localparam int AW    = 8;
    localparam int DEPTH = 150;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_x = '0;
    logic [DW-1:0] in_y = '0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_x;
    logic [DW-1:0] wr_y;
    logic [AW:0]   count;
    logic          done;
    logic          start_out;
`ifdef DATASET_WRITER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    dataset_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .count(count), .done(done), .start_out(start_out)
`ifdef DATASET_WRITER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int            cyc;
        int            addr;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } wr_t;

    wr_t wq[$];
    int  sq[$];

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0 idle, 1 loading, 2 final write in flight, 3 complete.
    int            m_phase = 0;
    int            m_ptr = 0;
    int            m_cnt = 0;
    int            m_cnt_vis = 0;
    bit            m_done = 0;
    bit            m_done_vis = 0;
    bit            exp_rdy = 0;
    logic [DW-1:0] m_sum = '0;
    logic [DW-1:0] m_sum_vis = '0;
    bit            run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit ls, input bit v, input logic [DW-1:0] x,
                        input logic [DW-1:0] y, input bit last);
        wr_t e;
        @(posedge clk);
        #1;
        load_start = ls;
        in_valid   = v;
        in_x       = x;
        in_y       = y;
        in_last    = last;
        m_cnt_vis  = m_cnt;
        m_done_vis = m_done;
        m_sum_vis  = m_sum;
        exp_rdy    = (m_phase == 1) && !ls;
        if (ls) begin
            m_phase = 1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_done  = 0;
            m_sum   = '0;
            while (sq.size() > 0 && sq[sq.size()-1] > cyc) void'(sq.pop_back());
        end else if (m_phase == 1 && v) begin
            e.cyc  = cyc;
            e.addr = m_ptr;
            e.x    = x;
            e.y    = y;
            wq.push_back(e);
            m_cnt = m_ptr + 1;
            m_sum = m_sum + x + y;
            if (last || m_ptr == DEPTH - 1) begin
                m_phase = 2;
                sq.push_back(cyc + 2);
            end else begin
                m_ptr = m_ptr + 1;
            end
        end else if (m_phase == 2) begin
            m_phase = 3;
            m_done  = 1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_start_out"}, 32'(start_out), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset      = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        m_phase = 0; m_ptr = 0; m_cnt = 0; m_cnt_vis = 0;
        m_done = 0; m_done_vis = 0; exp_rdy = 0;
        m_sum = '0; m_sum_vis = '0;
        wq.delete();
        sq.delete();
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (run && !reset) begin
            bit exp_we;
            bit exp_st;
            wr_t e;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("count", 32'(count), 32'(m_cnt_vis));
            chk("done", 32'(done), 32'(m_done_vis));
`ifdef DATASET_WRITER_CHECKSUM_EN
            chk("checksum", 32'(checksum), 32'(m_sum_vis));
`endif
            exp_st = (sq.size() > 0) && (sq[0] == cyc);
            chk("start_out", 32'(start_out), 32'(exp_st));
            if (exp_st) void'(sq.pop_front());
            exp_we = (wq.size() > 0) && (wq[0].cyc == cyc - 1);
            chk("wr_en", 32'(wr_en), 32'(exp_we));
            if (exp_we) begin
                e = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_x", 32'(wr_x), 32'(e.x));
                chk("wr_y", 32'(wr_y), 32'(e.y));
            end
        end
    end

    initial begin
        int guard;
        #2;
        chk_reset_outputs("reset");
        #1;
        reset = 1'b0;
        run = 1;
        idle(2);

        // Short set: X=1..4, Y=10..40, last on the 4th.
        step(1, 0, '0, '0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, DW'(i), DW'(i * 10), i == 4);
        idle(4);
        chk("short_count", 32'(count), 32'd4);
        chk("short_done", 32'(done), 32'd1);

        // Gapped stream 1,0,0,1,1.
        step(1, 0, '0, '0, 0);
        step(0, 1, 20'h11, 20'h22, 0);
        step(0, 0, 20'h99, 20'h99, 0);
        step(0, 0, 20'h98, 20'h98, 0);
        step(0, 1, 20'h33, 20'h44, 0);
        step(0, 1, 20'h55, 20'h66, 1);
        idle(3);

        // Restart mid-load with in_valid held high.
        step(1, 0, '0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, DW'($urandom()), DW'($urandom()), 0);
        step(1, 1, 20'hAAAAA, 20'h55555, 0);
        step(0, 1, 20'h12345, 20'h6789A, 0);
        chk("restart_done", 32'(done), 32'd0);
        step(0, 1, 20'h00001, 20'h00002, 0);
        step(0, 1, 20'h00003, 20'h00004, 1);
        idle(3);

        // Reset mid-load, then a fresh load from address 0.
        step(1, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, DW'($urandom()), DW'($urandom()), 0);
        do_reset();
        step(1, 0, '0, '0, 0);
        step(0, 1, 20'h00777, 20'h00888, 0);
        step(0, 1, 20'h00999, 20'h00AAA, 1);
        idle(3);

        // Full set: DEPTH samples, in_last never asserted, random gaps.
        step(1, 0, '0, '0, 0);
        guard = 0;
        while (m_phase == 1 && guard < 2000) begin
            step(0, $urandom_range(0, 3) != 0, DW'($urandom()), DW'($urandom()), 0);
            guard++;
        end
        chk("full_terminated", 32'(m_phase != 1), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 20'hBEEF0, 20'h0F00D, 0);
        idle(1);
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_done", 32'(done), 32'd1);

        // Checksum wrap: (5,7) + (0xFFFFF,2) = 0x0000D mod 2^20.
        step(1, 0, '0, '0, 0);
        step(0, 1, 20'h00005, 20'h00007, 0);
        step(0, 1, 20'hFFFFF, 20'h00002, 1);
        idle(3);
`ifdef DATASET_WRITER_CHECKSUM_EN
        chk("checksum_wrap", 32'(checksum), 32'h0000D);
`endif

        // Random loads with occasional restarts and random last.
        for (int l = 0; l < 8; l++) begin
            step(1, 0, '0, '0, 0);
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
                     DW'($urandom()), DW'($urandom()), $urandom_range(0, 15) == 0);
            idle(3);
        end

        run = 0;
        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("starts_drained", 32'(sq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
